// File: rtl/data_mem_stage.sv
// Memory stage: one registered output beat per accepted op, store/load/pass-through.
// Optional DMEM_CLEAR_EN zeroes the memory one word per cycle after reset.
module data_mem_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] result,
    input  logic [REG_W-1:0]  reg_addr,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              store_enable,
    input  logic              load_enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result_out,
    output logic [REG_W-1:0]  reg_addr_out,
    output logic              write_enable_out,
    output logic              conflict_out,
    output logic              state_dbg
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_store;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_load_data;

    // Handshake: a transfer happens on an edge where valid && ready on that side;
    // an op offered while in_ready=0 is left untouched for upstream to hold.
    assign in_ready    = (r_state == RUN) && (!out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_store     = w_accept && store_enable;
    assign w_load_data = r_mem[mem_addr];
    assign state_dbg   = (r_state == RUN);

`ifdef DMEM_CLEAR_EN
    logic [ADDR_W-1:0] r_clr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            if (&r_clr_cnt) begin
                r_state <= RUN;
            end
        end
    end

    assign w_mem_we    = !reset && ((r_state == CLEAR) || w_store);
    assign w_mem_waddr = (r_state == CLEAR) ? r_clr_cnt : mem_addr;
    assign w_mem_wdata = (r_state == CLEAR) ? '0 : result;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end
    end

    assign w_mem_we    = !reset && w_store;
    assign w_mem_waddr = mem_addr;
    assign w_mem_wdata = result;
`endif

    // Memory holds its contents through reset; only the sweep or a store writes it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid        <= 1'b0;
            result_out       <= '0;
            reg_addr_out     <= '0;
            write_enable_out <= 1'b0;
            conflict_out     <= 1'b0;
        end else if (w_accept) begin
            out_valid        <= 1'b1;
            result_out       <= (load_enable && !store_enable) ? w_load_data : result;
            reg_addr_out     <= reg_addr;
            write_enable_out <= write_enable;
            conflict_out     <= store_enable && load_enable;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
